// File: rtl/dcache_pkg.sv
// Shared types, size encodings and geometry helpers for the data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } dc_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic int unsigned off_bits(input int unsigned block_width);
    return $clog2(block_width / 8);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned address_width,
                                           input int unsigned block_width,
                                           input int unsigned num_sets);
    return address_width - idx_bits(num_sets) - off_bits(block_width);
  endfunction

  // Reverse the byte order of one 32-bit word.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/dcache_line_merge.sv
// Combinational lane logic: merges store data into a cached line and extracts
// extended load data from it. Lines are held in memory read order (byte i at
// line[8i+7:8i]), so lanes are little-endian.
module dcache_line_merge
  import dcache_pkg::*;
#(
  parameter int unsigned BLOCK_WIDTH = 128,
  parameter int unsigned DATA_WIDTH  = 32,
  localparam int unsigned OFF        = off_bits(BLOCK_WIDTH)
) (
  input  logic [BLOCK_WIDTH-1:0] line,
  input  logic [OFF-1:0]         addr,
  input  logic [1:0]             size,
  input  logic                   is_unsigned,
  input  logic [DATA_WIDTH-1:0]  wdata,
  output logic [BLOCK_WIDTH-1:0] merged,
  output logic [DATA_WIDTH-1:0]  rdata
);

  localparam int unsigned WORD_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] word;
  logic [7:0]            byte_val;
  logic [15:0]           half_val;
  int unsigned           word_base;
  int unsigned           byte_sel;
  int unsigned           half_sel;

  // Lane positions (in bytes within the line) and load extraction.
  always_comb begin
    word_base = 32'(addr[OFF-1:2]) * WORD_BYTES;
    byte_sel  = 32'(addr[1:0]);
    half_sel  = addr[1] ? 32'd2 : 32'd0;
    word      = line[word_base*8 +: DATA_WIDTH];
    byte_val  = word[byte_sel*8 +: 8];
    half_val  = word[half_sel*8 +: 16];
    case (size)
      SZ_BYTE: rdata = is_unsigned ? {{(DATA_WIDTH-8){1'b0}}, byte_val}
                                   : {{(DATA_WIDTH-8){byte_val[7]}}, byte_val};
      SZ_HALF: rdata = is_unsigned ? {{(DATA_WIDTH-16){1'b0}}, half_val}
                                   : {{(DATA_WIDTH-16){half_val[15]}}, half_val};
      default: rdata = word;
    endcase
  end

  // Store merge; size 11 behaves as a word.
  always_comb begin
    merged = line;
    case (size)
      SZ_BYTE: merged[(word_base + byte_sel)*8 +: 8]  = wdata[7:0];
      SZ_HALF: merged[(word_base + half_sel)*8 +: 16] = wdata[15:0];
      default: merged[word_base*8 +: DATA_WIDTH]      = wdata;
    endcase
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache in front of data_mem.
// Misses stall the CPU: clean miss COMPARE->ALLOCATE, dirty miss
// COMPARE->WRITEBACK->ALLOCATE, then the held request hits in COMPARE.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BLOCK_WIDTH   = 128,
  parameter int unsigned NUM_SETS      = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [1:0]               cpu_size,
  input  logic                     cpu_unsigned,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     stall,
  output logic                     mem_wr_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [BLOCK_WIDTH-1:0]   mem_wdata,
  input  logic [BLOCK_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned OFF = off_bits(BLOCK_WIDTH);
  localparam int unsigned IDX = idx_bits(NUM_SETS);
  localparam int unsigned TAG = tag_bits(ADDRESS_WIDTH, BLOCK_WIDTH, NUM_SETS);

  logic [OFF-1:0] off;
  logic [IDX-1:0] idx;
  logic [TAG-1:0] tag;

  assign off = cpu_addr[OFF-1:0];
  assign idx = cpu_addr[OFF +: IDX];
  assign tag = cpu_addr[ADDRESS_WIDTH-1 -: TAG];

  dc_state_t               state_q, state_d;
  logic [NUM_SETS-1:0]     valid_q, dirty_q;
  logic [TAG-1:0]          tag_q  [NUM_SETS];
  logic [BLOCK_WIDTH-1:0]  data_q [NUM_SETS];

  logic [BLOCK_WIDTH-1:0]  cur_line, merged_line, wb_line;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    req, hit, fill, store_hit;

  assign cur_line = data_q[idx];
  assign req      = cpu_re | cpu_we;
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);

  dcache_line_merge #(
    .BLOCK_WIDTH (BLOCK_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_merge (
    .line        (cur_line),
    .addr        (off),
    .size        (cpu_size),
    .is_unsigned (cpu_unsigned),
    .wdata       (cpu_wdata),
    .merged      (merged_line),
    .rdata       (load_data)
  );

  // Writeback image: data_mem expects every 32-bit word byte-reversed.
  always_comb begin
    wb_line = '0;
    for (int k = 0; k < int'(BLOCK_WIDTH / 32); k++) begin
      wb_line[32*k +: 32] = bswap32(cur_line[32*k +: 32]);
    end
  end

  // Next state and outputs; everything is held at its idle value while rst is high.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    fill      = 1'b0;
    store_hit = 1'b0;
    if (rst) begin
      state_d = COMPARE;
    end else begin
      case (state_q)
        COMPARE: begin
          if (req) begin
            if (hit) begin
              // With re and we both set, the load sees the pre-store line.
              if (cpu_re) cpu_rdata = load_data;
              store_hit = cpu_we;
            end else begin
              stall   = 1'b1;
              state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          stall     = 1'b1;
          mem_wr_en = 1'b1;
          mem_addr  = {tag_q[idx], idx, {OFF{1'b0}}};
          mem_wdata = wb_line;
          state_d   = ALLOCATE;
        end
        ALLOCATE: begin
          stall    = 1'b1;
          mem_addr = {tag, idx, {OFF{1'b0}}};
          fill     = 1'b1;
          state_d  = COMPARE;
        end
        default: state_d = COMPARE;
      endcase
    end
  end

  // FSM state and per-line valid/dirty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COMPARE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays; no reset, contents are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= tag;
    end else if (store_hit) begin
      data_q[idx] <= merged_line;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl with a behavioural data_mem. The reference model sees
// memory as a flat byte array from the CPU's point of view plus a tag table
// that predicts hit/miss, stall length and writeback contents.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  localparam int unsigned NSETS = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_re, cpu_we, cpu_unsigned;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic [1:0]   cpu_size;
  logic         stall, mem_wr_en;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  dcache_ctrl #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .BLOCK_WIDTH   (128),
    .NUM_SETS      (NSETS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_re       (cpu_re),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_size     (cpu_size),
    .cpu_unsigned (cpu_unsigned),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .stall        (stall),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- data_mem ----------------
  bit         wr_valid [0:65535];
  logic [7:0] wr_byte  [0:65535];

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    case (a)
      16'h0100: return 8'h11;
      16'h0101: return 8'h22;
      16'h0102: return 8'h33;
      16'h0103: return 8'h44;
      16'h0105: return 8'h80;
      default:  return a[7:0] ^ a[15:8];
    endcase
  endfunction

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return wr_valid[a] ? wr_byte[a] : init_byte(a);
  endfunction

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 16; i++) mem_rdata[8*i +: 8] = mem_byte(mem_addr[15:0] + 16'(i));
  end

  always @(posedge clk) begin
    if (mem_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < 4; j++) begin
          wr_valid[mem_addr[15:0] + 16'(4*k + j)] <= 1'b1;
          wr_byte[mem_addr[15:0] + 16'(4*k + j)]  <= mem_wdata[32*k + 31 - 8*j -: 8];
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]       view [0:65535];
  bit [NSETS-1:0]   m_valid, m_dirty;
  logic [19:0]      m_tag [NSETS];

  task automatic resync();
    for (int a = 0; a < 65536; a++) view[a] = mem_byte(16'(a));
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic uns);
    logic [15:0] p;
    logic [31:0] v;
    p = a[15:0];
    case (sz)
      SZ_BYTE: v = uns ? {24'h0, view[p]} : {{24{view[p][7]}}, view[p]};
      SZ_HALF: begin
        p[0] = 1'b0;
        v = {16'h0, view[p + 16'd1], view[p]};
        if (!uns) v[31:16] = {16{v[15]}};
      end
      default: begin
        p[1:0] = 2'b00;
        v = {view[p + 16'd3], view[p + 16'd2], view[p + 16'd1], view[p]};
      end
    endcase
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [15:0] p;
    p = a[15:0];
    case (sz)
      SZ_BYTE: view[p] = wd[7:0];
      SZ_HALF: begin
        p[0] = 1'b0;
        view[p] = wd[7:0];
        view[p + 16'd1] = wd[15:8];
      end
      default: begin
        p[1:0] = 2'b00;
        for (int i = 0; i < 4; i++) view[p + 16'(i)] = wd[8*i +: 8];
      end
    endcase
  endtask

  function automatic logic [127:0] wb_block(input logic [31:0] la);
    logic [127:0] b;
    b = '0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        b[32*k + 31 - 8*j -: 8] = view[la[15:0] + 16'(4*k + j)];
    return b;
  endfunction

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  logic         chk_en = 1'b0;
  logic         exp_stall, exp_wr, lit_en;
  logic [31:0]  exp_addr, exp_rdata, exp_lit;
  logic [127:0] exp_wdata;
  int           stall_seen = 0;
  int           wr_seen = 0;
  logic [31:0]  wb_addr_seen = '0;
  logic [31:0]  wb_word_seen = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 128'(stall), 128'(exp_stall));
      chk("mem_wr_en", 128'(mem_wr_en), 128'(exp_wr));
      chk("mem_addr", 128'(mem_addr), 128'(exp_addr));
      chk("mem_wdata", mem_wdata, exp_wdata);
      chk("cpu_rdata", 128'(cpu_rdata), 128'(exp_rdata));
      if (lit_en) chk("cpu_rdata_literal", 128'(cpu_rdata), 128'(exp_lit));
      if (stall === 1'b1) stall_seen++;
      if (mem_wr_en === 1'b1) begin
        wr_seen++;
        wb_addr_seen = mem_addr;
        wb_word_seen = mem_wdata[31:0];
      end
    end
  end

  // One clock with the expected outputs for it; inputs are already applied.
  task automatic cyc(input logic e_stall, input logic e_wr, input logic [31:0] e_addr,
                     input logic [127:0] e_wdata, input logic [31:0] e_rdata,
                     input logic l_en, input logic [31:0] l_val);
    exp_stall = e_stall;
    exp_wr    = e_wr;
    exp_addr  = e_addr;
    exp_wdata = e_wdata;
    exp_rdata = e_rdata;
    lit_en    = l_en;
    exp_lit   = l_val;
    chk_en    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One complete CPU access followed by an idle cycle.
  task automatic access(input logic re, input logic we, input logic [31:0] a,
                        input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                        input logic lit_on, input logic [31:0] lit, input int lit_stalls);
    int unsigned s;
    logic [19:0] t;
    logic        hit, wb;
    int          n;
    logic [31:0] old_line, new_line, ld;
    s        = 32'(a[11:4]);
    t        = a[31:12];
    hit      = m_valid[s] && (m_tag[s] == t);
    wb       = !hit && m_valid[s] && m_dirty[s];
    n        = hit ? 0 : (wb ? 3 : 2);
    old_line = {m_tag[s], a[11:4], 4'h0};
    new_line = {a[31:4], 4'h0};
    ld       = re ? model_load(a, sz, uns) : 32'h0;
    cpu_re = re; cpu_we = we; cpu_addr = a; cpu_size = sz; cpu_unsigned = uns; cpu_wdata = wd;
    stall_seen = 0;
    for (int c = 0; c <= n; c++) begin
      if (c == n)               cyc(1'b0, 1'b0, '0, '0, ld, lit_on, lit);
      else if (wb && c == 1)    cyc(1'b1, 1'b1, old_line, wb_block(old_line), '0, 1'b0, '0);
      else if (c == n - 1)      cyc(1'b1, 1'b0, new_line, '0, '0, 1'b0, '0);
      else                      cyc(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    end
    if (lit_stalls >= 0) chk("stall_cycles", 128'(stall_seen), 128'(lit_stalls));
    if (!hit) begin
      m_valid[s] = 1'b1;
      m_tag[s]   = t;
      m_dirty[s] = 1'b0;
    end
    if (we) begin
      model_store(a, sz, wd);
      m_dirty[s] = 1'b1;
    end
    cpu_re = 1'b0;
    cpu_we = 1'b0;
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1;
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_size = SZ_WORD;
    cpu_unsigned = 1'b0; cpu_wdata = '0;
    exp_stall = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
    lit_en = 1'b0; exp_lit = '0;
    m_valid = '0; m_dirty = '0;
    resync();
    @(posedge clk);
    #1;
    // Reset with a request pending: outputs must stay idle.
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    cpu_re = 1'b0;
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);

    // 1: clean miss on lw 0x100
    access(1'b1, 1'b0, 32'h100, SZ_WORD, 1'b0, '0, 1'b1, 32'h4433_2211, 2);
    chk("no_mem_write_1", 128'(wr_seen), 128'(0));

    // 2: hits within the resident line
    access(1'b1, 1'b0, 32'h104, SZ_WORD, 1'b0, '0, 1'b1, 32'h0607_8005, 0);
    access(1'b1, 1'b0, 32'h101, SZ_BYTE, 1'b1, '0, 1'b1, 32'h0000_0022, 0);
    access(1'b1, 1'b0, 32'h105, SZ_BYTE, 1'b0, '0, 1'b1, 32'hFFFF_FF80, 0);

    // 3: store hit makes the line dirty without touching memory
    access(1'b0, 1'b1, 32'h103, SZ_BYTE, 1'b0, 32'h0000_00AB, 1'b0, '0, 0);
    access(1'b1, 1'b0, 32'h100, SZ_WORD, 1'b0, '0, 1'b1, 32'hAB33_2211, 0);
    access(1'b1, 1'b0, 32'h102, SZ_WORD, 1'b0, '0, 1'b1, 32'hAB33_2211, 0);
    chk("no_mem_write_3", 128'(wr_seen), 128'(0));

    // 4: conflicting line forces a writeback
    access(1'b1, 1'b0, 32'h100 + NSETS * 16, SZ_WORD, 1'b0, '0, 1'b1, 32'h1213_1011, 3);
    chk("wb_count", 128'(wr_seen), 128'(1));
    chk("wb_addr", 128'(wb_addr_seen), 128'(32'h100));
    chk("wb_word0", 128'(wb_word_seen), 128'(32'h1122_33AB));
    chk("mem_byte_103", 128'(mem_byte(16'h0103)), 128'(8'hAB));

    // 5: half store on a clean miss, then half loads
    access(1'b0, 1'b1, 32'h10E, SZ_HALF, 1'b0, 32'h0000_BEEF, 1'b0, '0, 2);
    access(1'b1, 1'b0, 32'h10E, SZ_HALF, 1'b1, '0, 1'b1, 32'h0000_BEEF, 0);
    access(1'b1, 1'b0, 32'h10E, SZ_HALF, 1'b0, '0, 1'b1, 32'hFFFF_BEEF, 0);
    access(1'b1, 1'b0, 32'h10F, SZ_HALF, 1'b1, '0, 1'b1, 32'h0000_BEEF, 0);
    // load+store together returns the pre-store word
    access(1'b1, 1'b1, 32'h108, SZ_WORD, 1'b0, 32'h0102_0304, 1'b1, 32'h0A0B_0809, 0);
    access(1'b1, 1'b0, 32'h108, SZ_WORD, 1'b0, '0, 1'b1, 32'h0102_0304, 0);

    // 6: reset during a writeback discards it
    access(1'b1, 1'b0, 32'h200, SZ_WORD, 1'b0, '0, 1'b1, 32'h0100_0302, 2);
    access(1'b0, 1'b1, 32'h200, SZ_WORD, 1'b0, 32'hCAFE_F00D, 1'b0, '0, 0);
    cpu_re = 1'b1; cpu_addr = 32'h1200; cpu_size = SZ_WORD;
    cyc(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    rst = 1'b1;
    cpu_re = 1'b0;
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    m_valid = '0;
    m_dirty = '0;
    resync();
    rst = 1'b0;
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    chk("mem_byte_200", 128'(mem_byte(16'h0200)), 128'(8'h02));
    access(1'b1, 1'b0, 32'h200, SZ_WORD, 1'b0, '0, 1'b1, 32'h0100_0302, 2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
